ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32I pipeline; directly downstream of the decode stage and consumes its IdEx_* pipeline register.
- Selects forwarded operands, runs the ALU and resolves branches and jumps.
- Drives the PC redirect and the Ex_IdExFlush signal back to fetch and decode.
- Registers its results into the ExMem pipeline register that feeds the memory stage.

---
 rtl/ex_stage.sv | 148 ++++++++++++++
 tb/tb_ex_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the ExMem register.
// Redirect and flush are combinational; everything bound for the memory stage is registered.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic [XLEN-1:0] IdEx_Pc,
  input  logic [XLEN-1:0] IdEx_RegDataA,
  input  logic [XLEN-1:0] IdEx_RegDataB,
  input  logic [XLEN-1:0] IdEx_Imm,
  input  logic [4:0]      IdEx_RegRs1,
  input  logic [4:0]      IdEx_RegRs2,
  input  logic [4:0]      IdEx_RegRd,
  input  logic [3:0]      IdEx_AluOp,
  input  logic            IdEx_AluSrc,
  input  logic            IdEx_PcSrc,
  input  logic            IdEx_Branch,
  input  logic            IdEx_AluB_Pc4_Sel,
  input  logic            IdEx_MemRead,
  input  logic            IdEx_MemWrite,
  input  logic            IdEx_MemToReg,
  input  logic            IdEx_RegWrite,
  input  logic            MemWb_RegWrite,
  input  logic [4:0]      MemWb_RegRd,
  input  logic [XLEN-1:0] Wb_RegWData,
  output logic            Ex_IdExFlush,
  output logic            Ex_PcRedirect,
  output logic [XLEN-1:0] Ex_PcTarget,
  output logic [XLEN-1:0] ExMem_AluResult,
  output logic [XLEN-1:0] ExMem_StoreData,
  output logic [4:0]      ExMem_RegRd,
  output logic            ExMem_MemRead,
  output logic            ExMem_MemWrite,
  output logic            ExMem_MemToReg,
  output logic            ExMem_RegWrite
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_SLL  = 4'd2,  ALU_SLT   = 4'd3,
    ALU_SLTU = 4'd4,  ALU_XOR  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA   = 4'd7,
    ALU_OR   = 4'd8,  ALU_AND  = 4'd9,  ALU_PASSB = 4'd10, ALU_EQ   = 4'd11,
    ALU_NE   = 4'd12, ALU_GE   = 4'd13, ALU_GEU  = 4'd14, ALU_ZERO  = 4'd15
  } alu_op_e;

  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [4:0]      reg_rd_q, reg_rd_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            mem_to_reg_q, mem_to_reg_d;
  logic            reg_write_q, reg_write_d;

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_out;
  logic [4:0]      shamt;
  logic            branch_taken, jump, redirect;

  // Forward from the older instruction in EX/MEM first; loads there are covered by the decode stall.
  function automatic logic [XLEN-1:0] forward(input logic [4:0] rs, input logic [XLEN-1:0] rf_data);
    if (reg_write_q && !mem_read_q && (reg_rd_q != 5'd0) && (reg_rd_q == rs))
      return alu_result_q;
    else if (MemWb_RegWrite && (MemWb_RegRd != 5'd0) && (MemWb_RegRd == rs))
      return Wb_RegWData;
    else
      return rf_data;
  endfunction

  always_comb begin
    fwd_a = forward(IdEx_RegRs1, IdEx_RegDataA);
    fwd_b = forward(IdEx_RegRs2, IdEx_RegDataB);
    op_b  = IdEx_AluSrc ? IdEx_Imm : fwd_b;
    shamt = op_b[4:0];
    alu_out = '0;
    case (alu_op_e'(IdEx_AluOp))
      ALU_ADD:   alu_out = fwd_a + op_b;
      ALU_SUB:   alu_out = fwd_a - op_b;
      ALU_SLL:   alu_out = fwd_a << shamt;
      ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
      ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, fwd_a < op_b};
      ALU_XOR:   alu_out = fwd_a ^ op_b;
      ALU_SRL:   alu_out = fwd_a >> shamt;
      ALU_SRA:   alu_out = $unsigned($signed(fwd_a) >>> shamt);
      ALU_OR:    alu_out = fwd_a | op_b;
      ALU_AND:   alu_out = fwd_a & op_b;
      ALU_PASSB: alu_out = op_b;
      ALU_EQ:    alu_out = {{(XLEN-1){1'b0}}, fwd_a == op_b};
      ALU_NE:    alu_out = {{(XLEN-1){1'b0}}, fwd_a != op_b};
      ALU_GE:    alu_out = {{(XLEN-1){1'b0}}, $signed(fwd_a) >= $signed(op_b)};
      ALU_GEU:   alu_out = {{(XLEN-1){1'b0}}, fwd_a >= op_b};
      default:   alu_out = '0;
    endcase
  end

  // PcSrc survives bubbles, so only Pc4_Sel (cleared on bubbles) qualifies a jump.
  always_comb begin
    branch_taken = IdEx_Branch & alu_out[0];
    jump         = IdEx_PcSrc & IdEx_AluB_Pc4_Sel;
    redirect     = rstb & (branch_taken | jump);
    Ex_PcTarget  = '0;
    if (redirect) begin
      if (jump && IdEx_AluSrc)
        Ex_PcTarget = (fwd_a + IdEx_Imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
      else
        Ex_PcTarget = IdEx_Pc + IdEx_Imm;
    end
    Ex_PcRedirect = redirect;
    Ex_IdExFlush  = redirect;
  end

  always_comb begin
    alu_result_d = IdEx_AluB_Pc4_Sel ? (IdEx_Pc + XLEN'(4)) : alu_out;
    store_data_d = fwd_b;
    reg_rd_d     = IdEx_RegRd;
    mem_read_d   = IdEx_MemRead;
    mem_write_d  = IdEx_MemWrite;
    mem_to_reg_d = IdEx_MemToReg;
    reg_write_d  = IdEx_RegWrite;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      alu_result_q <= '0;
      store_data_q <= '0;
      reg_rd_q     <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      reg_rd_q     <= reg_rd_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
    end
  end

  assign ExMem_AluResult = alu_result_q;
  assign ExMem_StoreData = store_data_q;
  assign ExMem_RegRd     = reg_rd_q;
  assign ExMem_MemRead   = mem_read_q;
  assign ExMem_MemWrite  = mem_write_q;
  assign ExMem_MemToReg  = mem_to_reg_q;
  assign ExMem_RegWrite  = reg_write_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases with literal expectations, then random instructions
// checked every cycle against a behavioural model of the execute stage.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] pc, rda, rdb, imm, wb_data;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic [3:0]  aluop;
  logic        alusrc, pcsrc, branch, pc4, mr, mw, m2r, rw, wb_rw;

  logic        flush, redir;
  logic [31:0] target, xm_res, xm_sd;
  logic [4:0]  xm_rd;
  logic        xm_mr, xm_mw, xm_m2r, xm_rw;

  int n_checks = 0;
  int n_pass = 0;

  // model of the ExMem register contents and of the next values to be loaded
  logic [31:0] m_res, m_sd, e_res, e_sd, e_target;
  logic [4:0]  m_rd, e_rd;
  logic        m_mr, m_mw, m_m2r, m_rw, e_mr, e_mw, e_m2r, e_rw, e_redir;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rstb(rstb),
    .IdEx_Pc(pc), .IdEx_RegDataA(rda), .IdEx_RegDataB(rdb), .IdEx_Imm(imm),
    .IdEx_RegRs1(rs1), .IdEx_RegRs2(rs2), .IdEx_RegRd(rd), .IdEx_AluOp(aluop),
    .IdEx_AluSrc(alusrc), .IdEx_PcSrc(pcsrc), .IdEx_Branch(branch), .IdEx_AluB_Pc4_Sel(pc4),
    .IdEx_MemRead(mr), .IdEx_MemWrite(mw), .IdEx_MemToReg(m2r), .IdEx_RegWrite(rw),
    .MemWb_RegWrite(wb_rw), .MemWb_RegRd(wb_rd), .Wb_RegWData(wb_data),
    .Ex_IdExFlush(flush), .Ex_PcRedirect(redir), .Ex_PcTarget(target),
    .ExMem_AluResult(xm_res), .ExMem_StoreData(xm_sd), .ExMem_RegRd(xm_rd),
    .ExMem_MemRead(xm_mr), .ExMem_MemWrite(xm_mw), .ExMem_MemToReg(xm_m2r),
    .ExMem_RegWrite(xm_rw)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    int unsigned sh;
    sa = a; sb = b; sh = b % 32;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7:  return 32'(sa >>> sh);
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      4'd11: return (a == b) ? 32'd1 : 32'd0;
      4'd12: return (a != b) ? 32'd1 : 32'd0;
      4'd13: return (sa >= sb) ? 32'd1 : 32'd0;
      4'd14: return (a >= b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd_ref(input logic [4:0] rs, input logic [31:0] rf);
    if (rs != 0 && m_rw && !m_mr && m_rd == rs) return m_res;
    if (rs != 0 && wb_rw && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  task automatic model_eval();
    logic [31:0] a, b, y;
    logic jmp, tkn;
    a = fwd_ref(rs1, rda);
    b = fwd_ref(rs2, rdb);
    y = alu_ref(aluop, a, alusrc ? imm : b);
    jmp = pcsrc && pc4;
    tkn = branch && y[0];
    e_redir = rstb && (jmp || tkn);
    if (!e_redir) e_target = 0;
    else if (jmp && alusrc) e_target = (a + imm) & 32'hFFFF_FFFE;
    else e_target = pc + imm;
    e_res = pc4 ? pc + 4 : y;
    e_sd = b; e_rd = rd; e_mr = mr; e_mw = mw; e_m2r = m2r; e_rw = rw;
  endtask

  task automatic model_clear();
    m_res = 0; m_sd = 0; m_rd = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_rw = 0;
  endtask

  task automatic nop();
    pc = 0; rda = 0; rdb = 0; imm = 0; rs1 = 0; rs2 = 0; rd = 0; aluop = 0;
    alusrc = 0; pcsrc = 0; branch = 0; pc4 = 0; mr = 0; mw = 0; m2r = 0; rw = 0;
    wb_rw = 0; wb_rd = 0; wb_data = 0;
  endtask

  // inputs were just changed; let them settle and compare the combinational outputs
  task automatic settle_check();
    #1;
    model_eval();
    chk("flush", {31'd0, flush}, {31'd0, e_redir});
    chk("redirect", {31'd0, redir}, {31'd0, e_redir});
    chk("target", target, e_target);
  endtask

  task automatic check_exmem();
    chk("exmem_res", xm_res, m_res);
    chk("exmem_sd", xm_sd, m_sd);
    chk("exmem_ctl", {22'd0, xm_rd, xm_mr, xm_mw, xm_m2r, xm_rw}, {22'd0, m_rd, m_mr, m_mw, m_m2r, m_rw});
  endtask

  task automatic clock_check();
    @(posedge clk);
    if (rstb) begin
      m_res = e_res; m_sd = e_sd; m_rd = e_rd; m_mr = e_mr; m_mw = e_mw; m_m2r = e_m2r; m_rw = e_rw;
    end
    #1;
    check_exmem();
  endtask

  task automatic fwd_case(input logic first_rw, input logic [4:0] s1, input logic [31:0] exp, input string name);
    nop(); rda = 32'h10; alusrc = 1; rd = 1; rw = first_rw;
    settle_check(); clock_check();
    nop(); rs1 = s1; rda = 32'h99; alusrc = 1; rd = 5; rw = 1;
    wb_rw = 1; wb_rd = 1; wb_data = 32'h20;
    settle_check(); clock_check();
    chk(name, xm_res, exp);
  endtask

  initial begin
    nop();
    model_clear();
    rstb = 0;
    repeat (2) @(posedge clk);
    #1;
    check_exmem();
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_redirect", {31'd0, redir}, 32'd0);
    @(negedge clk);
    rstb = 1;
    @(posedge clk); #1;

    // 1: plain ADD
    nop(); rda = 5; rdb = 7; rs1 = 1; rs2 = 2; rd = 3; rw = 1;
    settle_check();
    chk("add_flush", {31'd0, flush}, 32'd0);
    clock_check();
    chk("add_res", xm_res, 32'd12);
    chk("add_rd", {27'd0, xm_rd}, 32'd3);
    chk("add_rw", {31'd0, xm_rw}, 32'd1);

    // 2: forwarding priority
    fwd_case(1'b1, 5'd1, 32'h10, "fwd_exmem_prio");
    fwd_case(1'b0, 5'd1, 32'h20, "fwd_memwb");
    fwd_case(1'b1, 5'd0, 32'h99, "fwd_rs0");

    // 3: BEQ taken / not taken
    nop(); pc = 32'h100; imm = 32'h20; rda = 32'h55; rdb = 32'h55; rs1 = 6; rs2 = 7;
    aluop = 4'd11; branch = 1;
    settle_check();
    chk("beq_redirect", {31'd0, redir}, 32'd1);
    chk("beq_target", target, 32'h120);
    chk("beq_flush", {31'd0, flush}, 32'd1);
    clock_check();
    rdb = 32'h56;
    settle_check();
    chk("bne_redirect", {31'd0, redir}, 32'd0);
    chk("bne_flush", {31'd0, flush}, 32'd0);
    chk("bne_target", target, 32'd0);
    clock_check();

    // 4: JALR and its bubble
    nop(); pc = 32'h40; rs1 = 8; rda = 32'h1003; imm = 4; alusrc = 1; pcsrc = 1; pc4 = 1; rd = 1; rw = 1;
    settle_check();
    chk("jalr_redirect", {31'd0, redir}, 32'd1);
    chk("jalr_target", target, 32'h1006);
    clock_check();
    chk("jalr_link", xm_res, 32'h44);
    pc4 = 0; rw = 0;
    settle_check();
    chk("bubble_redirect", {31'd0, redir}, 32'd0);
    clock_check();

    // 5: SRA, SLTU, SLT
    nop(); rs1 = 9; rda = 32'h8000_0000; alusrc = 1; imm = 35; aluop = 4'd7; rd = 2; rw = 1;
    settle_check(); clock_check();
    chk("sra", xm_res, 32'hF000_0000);
    nop(); rs1 = 9; rs2 = 10; rda = 1; rdb = 32'hFFFF_FFFF; aluop = 4'd4; rd = 2; rw = 1;
    settle_check(); clock_check();
    chk("sltu", xm_res, 32'd1);
    aluop = 4'd3;
    settle_check(); clock_check();
    chk("slt", xm_res, 32'd0);

    // 6: asynchronous reset mid-stream
    nop(); rda = 5; rdb = 7; rs2 = 2; rd = 3; rw = 1; mw = 1; m2r = 1;
    settle_check(); clock_check();
    pcsrc = 1; pc4 = 1;
    #2;
    rstb = 0;
    #1;
    model_clear();
    check_exmem();
    chk("rst_res_zero", xm_res, 32'd0);
    chk("rst_redirect", {31'd0, redir}, 32'd0);
    @(negedge clk);
    rstb = 1;
    @(posedge clk); #1;

    // random instruction stream; small register indices keep hazards frequent
    for (int i = 0; i < 400; i++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      rda = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      rdb = ($urandom_range(0, 3) == 0) ? rda : $urandom;
      imm = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom;
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
      aluop = 4'($urandom_range(0, 15));
      alusrc = 1'($urandom); pcsrc = 1'($urandom); branch = 1'($urandom); pc4 = ($urandom_range(0, 3) == 0);
      rw = 1'($urandom); mr = ($urandom_range(0, 3) == 0); mw = 1'($urandom); m2r = 1'($urandom);
      wb_rw = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = $urandom;
      settle_check();
      clock_check();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
